// File: rtl/mips32_mem_pkg.sv
// Shared types and defaults for the Mips32 memory responder: the response
// record carried through the delay pipeline and response FIFO.
package mips32_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEFAULT_DEPTH   = 1024;
  localparam int DEFAULT_LATENCY = 2;
  localparam int DEFAULT_QDEPTH  = 4;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_t;

endpackage

// File: rtl/mips32_resp_fifo.sv
// Synchronous FIFO holding in-order responses. Pointers are modulo-DEPTH
// indices with an extra wrap bit, so DEPTH need not be a power of two.
module mips32_resp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]   store [DEPTH];
  logic [IDX_W:0] wr_ptr;
  logic [IDX_W:0] rd_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [IDX_W:0] ptr_inc(input logic [IDX_W:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
      ptr_inc = {~p[IDX_W], {IDX_W{1'b0}}};
    end else begin
      ptr_inc = p + (IDX_W + 1)'(1);
    end
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Entry storage is not reset; only the pointers define what is live.
  always_ff @(posedge clk1) begin
    if (do_push) store[wr_ptr[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder for the Mips32 core: array, delay pipeline,
// credit counter and response FIFO. Optional MIPS32_MEM_BOUNDS_CHECK_EN flags out-of-range addresses.
module mips32_mem_responder
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int QDEPTH  = DEFAULT_QDEPTH
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  // Handshake: a request transfers on an edge with req_valid && req_ready, a
  // response on an edge with resp_valid && resp_ready; the presenting side
  // holds its payload stable until that edge.

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              pop;
  logic              oob;
  resp_t             rd_resp;
  logic              stg_valid [LATENCY];
  resp_t             stg_resp  [LATENCY];
  resp_t             head;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [CNT_W-1:0]  cnt;

  assign idx    = req_addr[ADDR_W-1:0];
  assign accept = req_valid && req_ready;
  assign pop    = resp_valid && resp_ready;

`ifdef MIPS32_MEM_BOUNDS_CHECK_EN
  assign oob = |req_addr[WORD_W-1:ADDR_W];
`else
  logic unused_addr_hi;
  assign oob            = 1'b0;
  assign unused_addr_hi = ^req_addr[WORD_W-1:ADDR_W];
`endif

  always_comb begin
    rd_resp     = '0;
    rd_resp.err = oob;
    if (!req_we && !oob) rd_resp.rdata = mem[idx];
  end

  // The write lands on the accept edge, so a load accepted next edge sees it.
  always_ff @(posedge clk1) begin
    if (accept && req_we && !oob) mem[idx] <= req_wdata;
  end

  // Stage 0 is the array read register; the rest are pure delay.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg_valid[i] <= 1'b0;
        stg_resp[i]  <= '0;
      end
    end else begin
      stg_valid[0] <= accept;
      if (accept) stg_resp[0] <= rd_resp;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_resp[i]  <= stg_resp[i-1];
      end
    end
  end

  mips32_resp_fifo #(
    .W     ($bits(resp_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk1  (clk1),
    .rst_n (rst_n),
    .push  (stg_valid[LATENCY-1]),
    .pop   (pop),
    .din   (stg_resp[LATENCY-1]),
    .dout  (head),
    .full  (fifo_full_unused),
    .empty (fifo_empty)
  );

  // Credits cover every accepted request not yet popped, so the FIFO can
  // never overflow and req_ready depends on registered state only.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign req_ready  = (cnt < CNT_W'(QDEPTH));
  assign resp_valid = !fifo_empty;
  assign resp_rdata = resp_valid ? head.rdata : '0;

`ifdef MIPS32_MEM_BOUNDS_CHECK_EN
  assign resp_err = resp_valid && head.err;
`else
  logic unused_head_err;
  assign resp_err        = 1'b0;
  assign unused_head_err = head.err;
`endif

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench for mips32_mem_responder (default parameters, LATENCY=2,
// QDEPTH=4); the bounds scenario follows MIPS32_MEM_BOUNDS_CHECK_EN.
module tb_mips32_mem_responder;

  localparam int LAT = 2;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  mips32_mem_responder dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Presents one request and returns at the sample point after its accept edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit done = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int n = 0; n < 50 && !done; n++) begin
      if (req_ready === 1'b1) done = 1;
      step();
    end
    req_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: addr %h not accepted within 50 cycles", addr);
    end
  endtask

  // Waits for the next response with resp_ready=1; waited=-1 on timeout.
  task automatic get_resp(output logic [31:0] d, output logic e, output int waited);
    bit found = 0;
    d = '0;
    e = 1'b0;
    waited = -1;
    resp_ready = 1'b1;
    for (int n = 0; n < 50 && !found; n++) begin
      if (resp_valid === 1'b1) begin
        d = resp_rdata;
        e = resp_err;
        waited = n;
        found = 1;
      end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk1);
    #3 rst_n = 1'b1;
    step();
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    vectors++;
    if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    vectors++;
    if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    vectors++;
    if (dut.cnt !== 0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt); end
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    send(1'b1, 32'd5, 32'hDEADBEEF);
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_1: resp_valid %b want 0", resp_valid); end
    send(1'b0, 32'd5, 32'h0);
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_2: resp_valid %b want 0", resp_valid); end
    step();
    vectors++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL single_store_ack: valid %b rdata %h want 1/00000000", resp_valid, resp_rdata);
    end
    step();
    vectors++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_load: valid %b rdata %h err %b want 1/deadbeef/0", resp_valid, resp_rdata, resp_err);
    end
    step();
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained: resp_valid %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b1, 32'(i), 32'(i * 3));
    repeat (4) step();
    for (int t = 0; t < 20; t++) begin
      if (t < 16) begin
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL stream_req_ready t=%0d: got %b want 1", t, req_ready); end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'(t);
      end else begin
        req_valid = 1'b0;
      end
      if (t >= 3 && t < 19) begin
        vectors++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'((t - 3) * 3)) begin
          miscompares++;
          $display("FAIL stream_resp t=%0d: valid %b rdata %h want 1/%h", t, resp_valid, resp_rdata, 32'((t - 3) * 3));
        end
      end
      if (t == 19) begin
        vectors++;
        if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL stream_tail: resp_valid %b want 0", resp_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int p = 0;
    int got = 0;
    logic [31:0] exp;
    exp_q.delete();
    resp_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (p < 6) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'(p + 1);
        if (req_ready === 1'b1) begin exp_q.push_back(32'((p + 1) * 3)); p++; end
      end
      step();
    end
    vectors++;
    if (p !== 4) begin miscompares++; $display("FAIL full_accepted: got %0d want 4", p); end
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_req_ready: got %b want 0", req_ready); end
    vectors++;
    if (dut.cnt !== 4) begin miscompares++; $display("FAIL full_cnt: got %0d want 4", dut.cnt); end
    for (int n = 0; n < 3; n++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'd3) begin
        miscompares++;
        $display("FAIL full_head_stable n=%0d: valid %b rdata %h want 1/00000003", n, resp_valid, resp_rdata);
      end
      if (n < 2) step();
    end
    resp_ready = 1'b1;
    for (int n = 0; n < 40 && got < 6; n++) begin
      if (n == 0) begin
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_same_cycle: req_ready %b want 0", req_ready); end
      end
      if (n == 1) begin
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_pop: req_ready %b want 1", req_ready); end
      end
      if (p < 6) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'(p + 1);
        if (req_ready === 1'b1) begin exp_q.push_back(32'((p + 1) * 3)); p++; end
      end else begin
        req_valid = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        vectors++;
        if (resp_rdata !== exp) begin miscompares++; $display("FAIL full_order #%0d: got %h want %h", got, resp_rdata, exp); end
        got++;
      end
      step();
    end
    req_valid = 1'b0;
    vectors++;
    if (got !== 6 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL full_total: responses %0d want 6, left %0d want 0", got, exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic test_accept_pop();
    int got = 0;
    logic [31:0] exp;
    exp_q.delete();
    resp_ready = 1'b0;
    send(1'b0, 32'd7, 32'h0);
    send(1'b0, 32'd8, 32'h0);
    send(1'b0, 32'd9, 32'h0);
    repeat (3) step();
    vectors++;
    if (dut.cnt !== 3 || resp_valid !== 1'b1 || resp_rdata !== 32'd21) begin
      miscompares++;
      $display("FAIL ap_setup: cnt %0d valid %b rdata %h want 3/1/00000015", dut.cnt, resp_valid, resp_rdata);
    end
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'd10;
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    vectors++;
    if (dut.cnt !== 3) begin miscompares++; $display("FAIL ap_cnt: got %0d want 3", dut.cnt); end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ap_req_ready: got %b want 1", req_ready); end
    exp_q.push_back(32'd24);
    exp_q.push_back(32'd27);
    exp_q.push_back(32'd30);
    for (int n = 0; n < 20 && got < 3; n++) begin
      if (resp_valid === 1'b1) begin
        exp = exp_q.pop_front();
        vectors++;
        if (resp_rdata !== exp) begin miscompares++; $display("FAIL ap_order #%0d: got %h want %h", got, resp_rdata, exp); end
        got++;
      end
      step();
    end
    vectors++;
    if (got !== 3) begin miscompares++; $display("FAIL ap_total: responses %0d want 3", got); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        e;
    int          w;
    resp_ready = 1'b1;
    send(1'b1, 32'd20, 32'hCAFEF00D);
    repeat (4) step();
    resp_ready = 1'b0;
    send(1'b0, 32'd1, 32'h0);
    send(1'b0, 32'd2, 32'h0);
    send(1'b0, 32'd3, 32'h0);
    vectors++;
    if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre: resp_valid %b want 1", resp_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_async: resp_valid %b want 0", resp_valid); end
    vectors++;
    if (dut.cnt !== 0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_cnt: cnt %0d req_ready %b want 0/1", dut.cnt, req_ready);
    end
    #3 rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      vectors++;
      if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stale n=%0d: resp_valid %b want 0", n, resp_valid); end
    end
    send(1'b0, 32'd20, 32'h0);
    get_resp(d, e, w);
    vectors++;
    if (w !== LAT || d !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL rst_mid_keep: latency %0d data %h want %0d/cafef00d", w, d, LAT);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] d;
    logic        e;
    int          w;
`ifdef MIPS32_MEM_BOUNDS_CHECK_EN
    send(1'b0, 32'h400, 32'h0);
    get_resp(d, e, w);
    vectors++;
    if (w !== LAT || e !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL bounds_load: latency %0d err %b data %h want %0d/1/0", w, e, d, LAT);
    end
    send(1'b1, 32'h405, 32'h12345678);
    get_resp(d, e, w);
    vectors++;
    if (e !== 1'b1 || d !== 32'h0) begin miscompares++; $display("FAIL bounds_store_ack: err %b data %h want 1/0", e, d); end
    send(1'b0, 32'd5, 32'h0);
    get_resp(d, e, w);
    vectors++;
    if (e !== 1'b0 || d !== 32'd15) begin miscompares++; $display("FAIL bounds_unchanged: err %b data %h want 0/0000000f", e, d); end
`else
    send(1'b0, 32'h405, 32'h0);
    get_resp(d, e, w);
    vectors++;
    if (w !== LAT || e !== 1'b0 || d !== 32'd15) begin
      miscompares++;
      $display("FAIL alias_405: latency %0d err %b data %h want %0d/0/0000000f", w, e, d, LAT);
    end
    send(1'b0, 32'h8000_040F, 32'h0);
    get_resp(d, e, w);
    vectors++;
    if (e !== 1'b0 || d !== 32'd45) begin miscompares++; $display("FAIL alias_hi: err %b data %h want 0/0000002d", e, d); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_accept_pop();
    test_reset_mid();
    test_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
